// File: rtl/control_receiver.sv
// Receiver for a 3-wire serial control interface (CLK/DATA/LE) running asynchronously to clk_i.
// Good frames are written to an 8-entry register bank that is indexed by the low 3 bits of the received word.
module control_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int WORD_WIDTH  = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        CLK_i,
    input  logic        DATA_i,
    input  logic        LE_i,
    input  logic [2:0]  rd_addr_i,
    output logic [31:0] rd_data_o,
    output logic [31:0] word_o,
    output logic [2:0]  addr_o,
    output logic        word_valid_o,
    output logic        frame_err_o
);

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    localparam logic [5:0] CNT_FULL = 6'(WORD_WIDTH);
    localparam logic [5:0] CNT_SAT  = 6'(WORD_WIDTH + 1);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic [SYNC_STAGES-1:0] le_sync_q;
    logic                   clk_prev_q;
    logic                   data_prev_q;
    logic                   le_prev_q;

    logic                   clk_s;
    logic                   le_s;
    logic                   clk_rise;
    logic                   le_rise;

    state_t                 state_q;
    state_t                 state_d;
    logic                   shift_en;
    logic                   clear_cnt;
    logic                   do_load;

    logic [5:0]             count_q;
    logic [WORD_WIDTH-1:0]  shift_q;
    logic [31:0]            shift_word;
    logic [31:0]            bank_q [8];

    // Synchronizers reset to the bus idle levels so reset release never fakes an edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clk_sync_q  <= '0;
            data_sync_q <= '0;
            le_sync_q   <= '1;
            clk_prev_q  <= 1'b0;
            data_prev_q <= 1'b0;
            le_prev_q   <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], CLK_i};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], DATA_i};
            le_sync_q   <= {le_sync_q[SYNC_STAGES-2:0], LE_i};
            clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
            data_prev_q <= data_sync_q[SYNC_STAGES-1];
            le_prev_q   <= le_sync_q[SYNC_STAGES-1];
        end
    end

    assign clk_s    = clk_sync_q[SYNC_STAGES-1];
    assign le_s     = le_sync_q[SYNC_STAGES-1];
    assign clk_rise = clk_s & ~clk_prev_q;
    assign le_rise  = le_s & ~le_prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A load edge wins over a serial clock edge that is detected in the same cycle.
    always_comb begin
        state_d   = state_q;
        shift_en  = 1'b0;
        clear_cnt = 1'b0;
        do_load   = 1'b0;
        case (state_q)
            IDLE: begin
                clear_cnt = 1'b1;
                if (!le_s) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (le_rise) begin
                    state_d = LOAD;
                end else if (clk_rise) begin
                    shift_en = 1'b1;
                end
            end
            LOAD: begin
                do_load = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign shift_word = 32'(shift_q);

    // The data bit is taken from the edge-detect stage so that it lines up with clk_prev_q.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q      <= '0;
            shift_q      <= '0;
            word_o       <= '0;
            addr_o       <= '0;
            word_valid_o <= 1'b0;
            frame_err_o  <= 1'b0;
            rd_data_o    <= '0;
            for (int i = 0; i < 8; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            word_valid_o <= 1'b0;
            frame_err_o  <= 1'b0;
            rd_data_o    <= bank_q[rd_addr_i];
            if (clear_cnt) begin
                count_q <= '0;
            end
            if (shift_en) begin
                shift_q <= {shift_q[WORD_WIDTH-2:0], data_prev_q};
                if (count_q != CNT_SAT) begin
                    count_q <= count_q + 6'd1;
                end
            end
            if (do_load) begin
                if (count_q == CNT_FULL) begin
                    word_o                   <= shift_word;
                    addr_o                   <= shift_word[2:0];
                    bank_q[shift_word[2:0]]  <= shift_word;
                    word_valid_o             <= 1'b1;
                end else begin
                    frame_err_o <= 1'b1;
                end
            end
        end
    end

endmodule
